div_repsub: RTL

DIV_REPSUB -- requirements
Module: div_repsub

---
 rtl/div_pkg.sv | 19 +
 rtl/div_repsub_if.sv | 47 ++++
 rtl/div_datapath.sv | 95 +++++++++
 rtl/div_repsub.sv | 114 +++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the repeated-subtraction divider.
//   DIV_WIDTH   : default operand/result width in bits
//   div_state_e : controller states
// -----------------------------------------------------------------------------
package div_pkg;

    localparam int DIV_WIDTH = 16;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_SUB    = 3'd3,
        S_DONE   = 3'd4
    } div_state_e;

endpackage : div_pkg

// File: rtl/div_repsub_if.sv
// -----------------------------------------------------------------------------
// div_repsub_if
// Request/result bundle of the divider.
//   start     : request a division (requester -> divider)
//   data_in   : serial operand bus, dividend then divisor (requester -> divider)
//   quotient  : quotient register (divider -> requester)
//   remainder : remainder / working dividend (divider -> requester)
//   done      : results valid (divider -> requester)
//   busy      : operation in progress (divider -> requester)
//   dbz       : divide-by-zero flag, valid with done (divider -> requester)
// master = requester side, slave = divider side.
// -----------------------------------------------------------------------------
interface div_repsub_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             done;
    logic             busy;
    logic             dbz;

    modport master (
        output start,
        output data_in,
        input  quotient,
        input  remainder,
        input  done,
        input  busy,
        input  dbz
    );

    modport slave (
        input  start,
        input  data_in,
        output quotient,
        output remainder,
        output done,
        output busy,
        output dbz
    );

endinterface : div_repsub_if

// File: rtl/div_datapath.sv
// -----------------------------------------------------------------------------
// div_datapath
// Registers and arithmetic of the repeated-subtraction divider.
//   clk, rst_n  : clock, asynchronous active-low reset
//   ldA_i       : load data_i into A (working dividend / remainder)
//   ldB_i       : load data_i into divisor register B, clear dbz
//   clrQ_i      : clear quotient
//   decA_i      : A <= A - B
//   incQ_i      : quotient <= quotient + 1
//   setDbz_i    : flag divide-by-zero, quotient <= all ones
//   data_i      : operand bus
//   ge_o        : A >= B (unsigned)
//   eqz_o       : data_i == 0
//   a_o, q_o    : A and quotient registers
//   dbz_o       : divide-by-zero flag
// -----------------------------------------------------------------------------
module div_datapath
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ldA_i,
    input  logic             ldB_i,
    input  logic             clrQ_i,
    input  logic             decA_i,
    input  logic             incQ_i,
    input  logic             setDbz_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             ge_o,
    output logic             eqz_o,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] q_o,
    output logic             dbz_o
);

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic             dbz_q, dbz_d;

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        quot_d = quot_q;
        dbz_d  = dbz_q;

        if (ldA_i) begin
            a_d = data_i;
        end
        if (ldB_i) begin
            b_d   = data_i;
            dbz_d = 1'b0;
        end
        if (clrQ_i) begin
            quot_d = '0;
        end
        // A zero divisor is detected in the same cycle B is loaded, so the
        // flag and the saturated quotient must win over the clears above.
        if (setDbz_i) begin
            quot_d = '1;
            dbz_d  = 1'b1;
        end
        // The controller only asserts decA_i while ge_o is high, so this
        // subtraction cannot wrap.
        if (decA_i) begin
            a_d = a_q - b_q;
        end
        if (incQ_i) begin
            quot_d = quot_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            quot_q <= '0;
            dbz_q  <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            quot_q <= quot_d;
            dbz_q  <= dbz_d;
        end
    end

    assign ge_o  = (a_q >= b_q);
    assign eqz_o = (data_i == '0);
    assign a_o   = a_q;
    assign q_o   = quot_q;
    assign dbz_o = dbz_q;

endmodule : div_datapath

// File: rtl/div_repsub.sv
// -----------------------------------------------------------------------------
// div_repsub
// Unsigned divider by repeated subtraction. Operands arrive serially on
// data_in (dividend, then divisor) after a start request; the quotient is
// counted up one subtraction per clock.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : div_repsub_if.slave (start, data_in, quotient, remainder,
//           done, busy, dbz)
// -----------------------------------------------------------------------------
module div_repsub
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    div_repsub_if.slave  bus
);

    div_state_e state_q, state_d;

    logic ldA, ldB, clrQ, decA, incQ, setDbz;
    logic ge, eqz;
    logic [WIDTH-1:0] a_val, q_val;
    logic             dbz_val;

    div_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk      (clk),
        .rst_n    (rst_n),
        .ldA_i    (ldA),
        .ldB_i    (ldB),
        .clrQ_i   (clrQ),
        .decA_i   (decA),
        .incQ_i   (incQ),
        .setDbz_i (setDbz),
        .data_i   (bus.data_in),
        .ge_o     (ge),
        .eqz_o    (eqz),
        .a_o      (a_val),
        .q_o      (q_val),
        .dbz_o    (dbz_val)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ldA     = 1'b0;
        ldB     = 1'b0;
        clrQ    = 1'b0;
        decA    = 1'b0;
        incQ    = 1'b0;
        setDbz  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_LOAD_A;
                end
            end
            S_LOAD_A: begin
                ldA     = 1'b1;
                state_d = S_LOAD_B;
            end
            S_LOAD_B: begin
                ldB  = 1'b1;
                clrQ = 1'b1;
                if (eqz) begin
                    setDbz  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_SUB;
                end
            end
            S_SUB: begin
                if (ge) begin
                    decA = 1'b1;
                    incQ = 1'b1;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // Holding start high here must not retrigger; the request
                // has to drop (back to IDLE) before a new one is accepted.
                if (!bus.start) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status is decoded straight from the state register so that reset
    // clears it immediately, without waiting for a clock edge.
    assign bus.done      = (state_q == S_DONE);
    assign bus.busy      = (state_q == S_LOAD_A) || (state_q == S_LOAD_B) ||
                           (state_q == S_SUB);
    assign bus.quotient  = q_val;
    assign bus.remainder = a_val;
    assign bus.dbz       = dbz_val;

endmodule : div_repsub
